// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path and the command
// decoder that consumes its output.
//   - rxState_t : receiver FSM states (PARITY is only reachable when the
//                 receiver is built with UART_RX_PARITY_EN)
//   - calcDiv   : clocks per oversample tick for a given clock/baud/oversample
//   - CMD_*     : ASCII command characters decoded downstream
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rxState_t;

  // Integer division: any remainder shows up as a small baud-rate error,
  // which the mid-bit sampling point tolerates.
  function automatic int calcDiv(input int clkFreq, input int baud, input int overSample);
    return clkFreq / (baud * overSample);
  endfunction

  localparam logic [7:0] CMD_M_UPPER = 8'h4D;
  localparam logic [7:0] CMD_M_LOWER = 8'h6D;
  localparam logic [7:0] CMD_F_UPPER = 8'h46;
  localparam logic [7:0] CMD_F_LOWER = 8'h66;
  localparam logic [7:0] CMD_ONE     = 8'h31;
  localparam logic [7:0] CMD_FIVE    = 8'h35;
  localparam logic [7:0] CMD_A_UPPER = 8'h41;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divide-by-DIV counter producing the
// oversample tick for the UART receiver.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   clear  - synchronous clear; holds the counter at 0
//   enable - advance the counter
//   tick   - high for one clock when the counter is at DIV-1
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // Counter wraps from DIV-1 back to 0; clear wins over enable so a
  // restart always begins a full tick period.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART receive front end. Synchronises the serial line,
// deframes LSB-first characters (8N1, or 8E1 when UART_RX_PARITY_EN is
// defined) and presents each good byte on a held bus with a one-cycle strobe.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high reset
//   iRX         - asynchronous serial line, idles high
//   odata       - last correctly received byte, held until the next good one
//   oVALID      - one-cycle pulse when odata is updated
//   oFRAME_ERR  - one-cycle pulse when the stop bit is sampled low
//   oPARITY_ERR - one-cycle pulse on an even-parity mismatch (tied 0 when
//                 UART_RX_PARITY_EN is not defined)
//   oBUSY       - high while a frame is in progress
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRX,
  output logic [7:0] odata,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oPARITY_ERR,
  output logic       oBUSY
);

  localparam int DIV = calcDiv(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

  rxState_t      state, stateNext;
  logic          rxMeta, rxS, rxPrev;
  logic          startEdge, tick, bitDone;
  logic [SW-1:0] tickCnt, tickTarget;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          validNext, frameErrNext;
`ifdef UART_RX_PARITY_EN
  logic          parityBit, parityErrNext;
`endif

  assign startEdge = rxPrev & ~rxS;

  // The start bit is sampled after half a bit; every later bit one full
  // bit after the previous sample, so all samples land mid-bit.
  assign tickTarget = (state == START) ? HALF_LAST : FULL_LAST;
  assign bitDone    = tick && (tickCnt == tickTarget);
  assign oBUSY      = (state != IDLE);

  // Holding the divider clear in IDLE makes the first tick of a frame
  // land exactly DIV clocks after the start edge is seen.
  uart_baud_tick #(.DIV(DIV)) uBaudTick (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .enable(state != IDLE),
    .tick  (tick)
  );

  // Next-state and the stop-bit decision; the decision flags are
  // registered so the output pulses come one clock after mid-stop.
  always_comb begin
    stateNext    = state;
    validNext    = 1'b0;
    frameErrNext = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityErrNext = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (startEdge) stateNext = START;
      end
      START: begin
        if (bitDone) stateNext = rxS ? IDLE : DATA;
      end
      DATA: begin
        if (bitDone && (bitCnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          stateNext = PARITY;
`else
          stateNext = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (bitDone) stateNext = STOP;
`else
        stateNext = IDLE;
`endif
      end
      STOP: begin
        if (bitDone) begin
          stateNext = IDLE;
          if (!rxS) begin
            frameErrNext = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^shiftReg) != parityBit) begin
            parityErrNext = 1'b1;
`endif
          end else begin
            validNext = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Synchroniser, state register and receive datapath. The synchroniser
  // resets to the idle level so reset itself never looks like a start edge
  // on an idle line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxMeta     <= 1'b1;
      rxS        <= 1'b1;
      rxPrev     <= 1'b1;
      state      <= IDLE;
      tickCnt    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      odata      <= 8'h00;
      oVALID     <= 1'b0;
      oFRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBit   <= 1'b0;
      oPARITY_ERR <= 1'b0;
`endif
    end else begin
      rxMeta     <= iRX;
      rxS        <= rxMeta;
      rxPrev     <= rxS;
      state      <= stateNext;
      oVALID     <= validNext;
      oFRAME_ERR <= frameErrNext;

      if ((state == IDLE) || bitDone) begin
        tickCnt <= '0;
      end else if (tick) begin
        tickCnt <= tickCnt + 1'b1;
      end

      if (state != DATA) begin
        bitCnt <= '0;
      end else if (bitDone) begin
        bitCnt <= bitCnt + 1'b1;
      end

      // LSB arrives first, so shift right and insert at the top.
      if ((state == DATA) && bitDone) begin
        shiftReg <= {rxS, shiftReg[7:1]};
      end

      if (validNext) begin
        odata <= shiftReg;
      end

`ifdef UART_RX_PARITY_EN
      if ((state == PARITY) && bitDone) begin
        parityBit <= rxS;
      end
      oPARITY_ERR <= parityErrNext;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign oPARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed bench for uart_rx_byte at 160 clocks per bit.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_rx_byte;

  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD       = 10000;
  localparam int OVERSAMPLE = 16;
  localparam int DIV        = 10;
  localparam int BITCLK     = OVERSAMPLE * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAMEBITS  = 11;
`else
  localparam int FRAMEBITS  = 10;
`endif
  // 2 synchroniser clocks + mid-stop (9.5 bits, one more with parity) + 1
  localparam int LATENCY = 2 + (19 * BITCLK) / 2 + (FRAMEBITS - 10) * BITCLK + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       iRX;
  logic [7:0] odata;
  logic       oVALID, oFRAME_ERR, oPARITY_ERR, oBUSY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         vldCnt = 0, ferrCnt = 0, perrCnt = 0, clashCnt = 0;
  int         lastVldCyc = 0, prevVldCyc = 0;
  logic [7:0] lastVldData = 8'h00, prevVldData = 8'h00;
  logic       anyPulse = 1'b0, prevPulse = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       parityFlip = 1'b0;
`endif

  uart_rx_byte #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iRX        (iRX),
    .odata      (odata),
    .oVALID     (oVALID),
    .oFRAME_ERR (oFRAME_ERR),
    .oPARITY_ERR(oPARITY_ERR),
    .oBUSY      (oBUSY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse recorder, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    anyPulse = (oVALID === 1'b1) || (oFRAME_ERR === 1'b1) || (oPARITY_ERR === 1'b1);
    if (oVALID === 1'b1) begin
      vldCnt++;
      prevVldCyc  = lastVldCyc;
      prevVldData = lastVldData;
      lastVldCyc  = cyc;
      lastVldData = odata;
    end
    if (oFRAME_ERR === 1'b1) ferrCnt++;
    if (oPARITY_ERR === 1'b1) perrCnt++;
    if (((int'(oVALID === 1'b1) + int'(oFRAME_ERR === 1'b1) + int'(oPARITY_ERR === 1'b1)) > 1) ||
        (anyPulse && prevPulse)) clashCnt++;
    prevPulse = anyPulse;
  end

  task automatic applyStimulus(input logic b, input int n);
    iRX = b;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; counts mid-bit samples of start/data bits where oBUSY
  // was not high.
  task automatic sendFrame(input logic [7:0] d, input logic stopBit,
                           output int busyLow, output int startCyc);
    logic [8:0] frame;
    frame    = {d, 1'b0};
    busyLow  = 0;
    startCyc = cyc;
    for (int i = 0; i < 9; i++) begin
      iRX = frame[i];
      repeat (BITCLK / 2) @(negedge clk);
      if (oBUSY !== 1'b1) busyLow++;
      repeat (BITCLK / 2) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    applyStimulus((^d) ^ parityFlip, BITCLK);
`endif
    applyStimulus(stopBit, BITCLK);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    iRX   = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (odata !== 8'h00) begin bad++; $display("[TB] FAIL reset_odata: got %h want %h", odata, 8'h00); end
    total++; if (oVALID !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", oVALID); end
    total++; if (oFRAME_ERR !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr: got %b want 0", oFRAME_ERR); end
    total++; if (oPARITY_ERR !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr: got %b want 0", oPARITY_ERR); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", oBUSY); end
  endtask

  task automatic test_good_frame;
    int v0, f0, p0, busyLow, startCyc, lat;
    v0 = vldCnt; f0 = ferrCnt; p0 = perrCnt;
    sendFrame(8'h4D, 1'b1, busyLow, startCyc);
    applyStimulus(1'b1, 20);
    lat = lastVldCyc - startCyc;
    total++; if (vldCnt - v0 != 1) begin bad++; $display("[TB] FAIL good_valid_count: got %0d want 1", vldCnt - v0); end
    total++; if (lat < LATENCY - 1 || lat > LATENCY + 1) begin bad++; $display("[TB] FAIL good_latency: got %0d want %0d", lat, LATENCY); end
    total++; if (odata !== 8'h4D) begin bad++; $display("[TB] FAIL good_odata: got %h want %h", odata, 8'h4D); end
    total++; if (busyLow != 0) begin bad++; $display("[TB] FAIL good_busy: got %0d low samples want 0", busyLow); end
    total++; if (ferrCnt != f0 || perrCnt != p0) begin bad++; $display("[TB] FAIL good_no_err: got ferr+%0d perr+%0d want 0", ferrCnt - f0, perrCnt - p0); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("[TB] FAIL good_idle: got %b want 0", oBUSY); end
  endtask

  task automatic test_false_start;
    int v0, f0, p0;
    logic busyMid;
    v0 = vldCnt; f0 = ferrCnt; p0 = perrCnt;
    applyStimulus(1'b0, 20);
    busyMid = oBUSY;
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 100);
    total++; if (busyMid !== 1'b1) begin bad++; $display("[TB] FAIL false_busy_mid: got %b want 1", busyMid); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("[TB] FAIL false_busy_end: got %b want 0", oBUSY); end
    total++; if (vldCnt != v0 || ferrCnt != f0 || perrCnt != p0) begin bad++; $display("[TB] FAIL false_no_pulse: got vld+%0d ferr+%0d perr+%0d want 0", vldCnt - v0, ferrCnt - f0, perrCnt - p0); end
    total++; if (odata !== 8'h4D) begin bad++; $display("[TB] FAIL false_odata: got %h want %h", odata, 8'h4D); end
  endtask

  task automatic test_frame_error;
    int v0, f0, busyLow, startCyc;
    v0 = vldCnt; f0 = ferrCnt;
    sendFrame(8'h46, 1'b0, busyLow, startCyc);
    applyStimulus(1'b1, 200);
    total++; if (ferrCnt - f0 != 1) begin bad++; $display("[TB] FAIL ferr_count: got %0d want 1", ferrCnt - f0); end
    total++; if (vldCnt != v0) begin bad++; $display("[TB] FAIL ferr_no_valid: got %0d want 0", vldCnt - v0); end
    total++; if (odata !== 8'h4D) begin bad++; $display("[TB] FAIL ferr_odata: got %h want %h", odata, 8'h4D); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("[TB] FAIL ferr_idle: got %b want 0", oBUSY); end
  endtask

  task automatic test_back_to_back;
    int v0, busyLow, startCyc;
    v0 = vldCnt;
    sendFrame(8'h31, 1'b1, busyLow, startCyc);
    sendFrame(8'h35, 1'b1, busyLow, startCyc);
    applyStimulus(1'b1, 20);
    total++; if (vldCnt - v0 != 2) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 2", vldCnt - v0); end
    total++; if (lastVldCyc - prevVldCyc != FRAMEBITS * BITCLK) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", lastVldCyc - prevVldCyc, FRAMEBITS * BITCLK); end
    total++; if (prevVldData !== 8'h31) begin bad++; $display("[TB] FAIL b2b_first: got %h want %h", prevVldData, 8'h31); end
    total++; if (odata !== 8'h35) begin bad++; $display("[TB] FAIL b2b_odata: got %h want %h", odata, 8'h35); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0, f0, busyLow, startCyc;
    v0 = vldCnt; p0 = perrCnt; f0 = ferrCnt;
    parityFlip = 1'b1;
    sendFrame(8'h41, 1'b1, busyLow, startCyc);
    applyStimulus(1'b1, 20);
    total++; if (perrCnt - p0 != 1) begin bad++; $display("[TB] FAIL par_bad_perr: got %0d want 1", perrCnt - p0); end
    total++; if (vldCnt != v0 || ferrCnt != f0) begin bad++; $display("[TB] FAIL par_bad_other: got vld+%0d ferr+%0d want 0", vldCnt - v0, ferrCnt - f0); end
    total++; if (odata !== 8'h35) begin bad++; $display("[TB] FAIL par_bad_odata: got %h want %h", odata, 8'h35); end
    parityFlip = 1'b0;
    sendFrame(8'h41, 1'b1, busyLow, startCyc);
    applyStimulus(1'b1, 20);
    total++; if (vldCnt - v0 != 1) begin bad++; $display("[TB] FAIL par_good_valid: got %0d want 1", vldCnt - v0); end
    total++; if (perrCnt - p0 != 1) begin bad++; $display("[TB] FAIL par_good_perr: got %0d want 1", perrCnt - p0); end
    total++; if (odata !== 8'h41) begin bad++; $display("[TB] FAIL par_good_odata: got %h want %h", odata, 8'h41); end
  endtask
`endif

  // The transmitter abandons 8'h41 in data bit 4 while reset pulses; the
  // line is released high so nothing of the partial frame remains.
  task automatic test_reset_midframe;
    int v0, f0, p0, busyLow, startCyc;
    logic [7:0] frameBits;
    frameBits = 8'h41;
    v0 = vldCnt; f0 = ferrCnt; p0 = perrCnt;
    applyStimulus(1'b0, BITCLK);
    for (int i = 0; i < 4; i++) applyStimulus(frameBits[i], BITCLK);
    applyStimulus(frameBits[4], BITCLK / 2);
    reset = 1'b1;
    iRX   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (odata !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_odata: got %h want %h", odata, 8'h00); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b want 0", oBUSY); end
    applyStimulus(1'b1, 2000);
    total++; if (vldCnt != v0 || ferrCnt != f0 || perrCnt != p0) begin bad++; $display("[TB] FAIL rstmid_no_pulse: got vld+%0d ferr+%0d perr+%0d want 0", vldCnt - v0, ferrCnt - f0, perrCnt - p0); end
    sendFrame(8'h41, 1'b1, busyLow, startCyc);
    applyStimulus(1'b1, 20);
    total++; if (vldCnt - v0 != 1) begin bad++; $display("[TB] FAIL rstmid_next_valid: got %0d want 1", vldCnt - v0); end
    total++; if (odata !== 8'h41) begin bad++; $display("[TB] FAIL rstmid_next_odata: got %h want %h", odata, 8'h41); end
  endtask

  task automatic test_pulse_rules;
    total++; if (clashCnt != 0) begin bad++; $display("[TB] FAIL pulse_exclusive: got %0d clashes want 0", clashCnt); end
  endtask

  initial begin
    $display("[TB] uart_rx_byte bench, %0d clocks per bit", BITCLK);
    test_reset;
    test_good_frame;
    test_false_start;
    test_frame_error;
    test_back_to_back;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_reset_midframe;
    test_pulse_rules;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
